// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit common-anode seven-segment scan scheduler with per-slot
// blanking and frame-boundary data loading through a valid/ack handshake.
module seg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        data_valid,
    output logic        data_ack,
    output logic [3:0]  AN,
    output logic [7:0]  SEG,
    output logic        frame_done
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYCLES);

    state_t           r_state;
    logic [1:0]       r_digit;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_shadow;
    logic [3:0]       r_dp;
    logic             r_ack;
    logic             r_frame;

    logic             w_slot_end;
    logic             w_drive;
    logic [3:0]       w_nib;
    logic [6:0]       w_hex;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_slot_end = r_cnt == LAST;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_digit  <= 2'd0;
            r_cnt    <= '0;
            r_shadow <= 16'h0000;
            r_dp     <= 4'h0;
            r_ack    <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            r_frame <= 1'b0;
            if (r_state == IDLE) begin
                // IDLE accepts every cycle; a request held past its ack is captured again
                if (data_valid) begin
                    r_shadow <= data_in;
                    r_dp     <= dp_in;
                    r_ack    <= 1'b1;
                end
                r_state <= en ? SCAN : IDLE;
                r_digit <= 2'd0;
                r_cnt   <= '0;
            end else if (!en) begin
                r_state <= IDLE;
                r_digit <= 2'd0;
                r_cnt   <= '0;
            end else if (w_slot_end) begin
                r_cnt   <= '0;
                r_digit <= r_digit + 2'd1;
                if (r_digit == 2'd3) begin
                    r_frame <= 1'b1;
                    if (data_valid) begin
                        r_shadow <= data_in;
                        r_dp     <= dp_in;
                        r_ack    <= 1'b1;
                    end
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_drive = (r_state == SCAN) && (r_cnt >= BLANK);
        w_nib   = r_shadow[{r_digit, 2'b00} +: 4];
        w_hex   = hex7(w_nib);
        AN      = w_drive ? ~(4'b0001 << r_digit) : 4'b1111;
        SEG     = w_drive ? {~r_dp[r_digit], w_hex} : 8'hFF;
    end

    assign data_ack   = r_ack;
    assign frame_done = r_frame;
endmodule
